lstm_config_loader: RTL and testbench

Configuration sequencer for the multi-layer LSTM stack. It accepts a serial stream of weight and bias words on a ready/valid port and collects them into shadow registers. Once a full, correctly framed set has arrived, it commits the set atomically: all weight/bias buses update together with one-cycle valid strobes. Placed between the host config interface and the LSTM stack's weight/bias ports; a malformed or aborted load never disturbs the active configuration.

---
 rtl/lstm_config_loader.sv | 151 +++++++++++++++
 tb/tb_lstm_config_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/lstm_config_loader.sv
// Shadow-buffered LSTM weight/bias loader: 4 kinds x 4 gates x LAYERS words, committed atomically.
// Bus update, strobes and done come 1 cycle after the last accept; cfg_ready is a registered LOAD decode with no timeout on stalls.
`timescale 1ns/1ps
module lstm_config_loader #(
  parameter int LAYERS = 3,
  parameter int WIDTH = 16,
  localparam int WEIGHTS = 4,
  localparam int N_WORDS = LAYERS * 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic signed [WIDTH-1:0]                cfg_data,
  input  logic                                   cfg_valid,
  input  logic                                   cfg_last,
  output logic                                   cfg_ready,
  output logic [LAYERS*WEIGHTS-1:0][WIDTH-1:0]   weight_x,
  output logic [LAYERS*WEIGHTS-1:0]              weight_x_valid,
  output logic [LAYERS*WEIGHTS-1:0][WIDTH-1:0]   weight_h,
  output logic [LAYERS*WEIGHTS-1:0]              weight_h_valid,
  output logic [LAYERS*WEIGHTS-1:0][WIDTH-1:0]   bias_x,
  output logic [LAYERS*WEIGHTS-1:0]              bias_x_valid,
  output logic [LAYERS*WEIGHTS-1:0][WIDTH-1:0]   bias_h,
  output logic [LAYERS*WEIGHTS-1:0]              bias_h_valid,
  output logic                                   busy,
  output logic                                   loaded,
  output logic                                   done,
  output logic                                   err
);

  localparam int NG = LAYERS * WEIGHTS;
  localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int SW = (NG > 1) ? $clog2(NG) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  typedef logic [3:0][NG-1:0][WIDTH-1:0] cfg_set_t;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          loaded_q, loaded_d;
  logic          done_q, done_d;
  logic          strobe_q, strobe_d;
  logic          ready_q, ready_d;
  cfg_set_t      shadow_q, shadow_d;
  cfg_set_t      active_q, active_d;

  logic          accept;
  logic          is_final;
  logic [1:0]    kind_sel;
  logic [SW-1:0] slot_sel;

  // Word index i maps to kind (i/4)%4 and slot layer*4+gate, layer=i/16, gate=i%4.
  assign kind_sel = cnt_q[3:2];
  assign slot_sel = SW'({cnt_q >> 4, cnt_q[1:0]});
  assign accept   = cfg_valid && ready_q;
  assign is_final = (cnt_q == CW'(N_WORDS - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    strobe_d = 1'b0;
    shadow_d = shadow_q;
    active_d = active_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (accept) begin
          if (cfg_last && is_final) begin
            // Fold the final word straight into the active set so it lands with the strobes.
            shadow_d[kind_sel][slot_sel] = cfg_data;
            active_d = shadow_d;
            state_d  = S_COMMIT;
            done_d   = 1'b1;
            strobe_d = 1'b1;
            loaded_d = 1'b1;
          end else if (cfg_last || is_final) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            shadow_d[kind_sel][slot_sel] = cfg_data;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d = (state_d == S_LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      ready_q  <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
      strobe_q <= strobe_d;
      ready_q  <= ready_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign cfg_ready      = ready_q;
  assign weight_x       = active_q[0];
  assign weight_h       = active_q[1];
  assign bias_x         = active_q[2];
  assign bias_h         = active_q[3];
  assign weight_x_valid = {NG{strobe_q}};
  assign weight_h_valid = {NG{strobe_q}};
  assign bias_x_valid   = {NG{strobe_q}};
  assign bias_h_valid   = {NG{strobe_q}};
  assign busy           = (state_q != S_IDLE);
  assign loaded         = loaded_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_lstm_config_loader.sv
// Bench for lstm_config_loader: randomized loads, a reference model of the word layout, and a commit scoreboard.
`timescale 1ns/1ps
module tb_lstm_config_loader;

  localparam int LAYERS = 3;
  localparam int WIDTH  = 16;
  localparam int NG     = LAYERS * 4;
  localparam int N      = LAYERS * 16;

  typedef logic [3:0][NG-1:0][WIDTH-1:0] cfg_t;
  typedef struct {
    int   cyc;
    cfg_t cfg;
  } exp_t;

  logic clk, rst, start, abort, cfg_valid, cfg_last, cfg_ready;
  logic signed [WIDTH-1:0] cfg_data;
  logic [NG-1:0][WIDTH-1:0] weight_x, weight_h, bias_x, bias_h;
  logic [NG-1:0] weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid;
  logic busy, loaded, done, err;

  lstm_config_loader #(.LAYERS(LAYERS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_last(cfg_last), .cfg_ready(cfg_ready),
    .weight_x(weight_x), .weight_x_valid(weight_x_valid),
    .weight_h(weight_h), .weight_h_valid(weight_h_valid),
    .bias_x(bias_x), .bias_x_valid(bias_x_valid),
    .bias_h(bias_h), .bias_h_valid(bias_h_valid),
    .busy(busy), .loaded(loaded), .done(done), .err(err)
  );

  exp_t sb[$];
  cfg_t ref_act;
  bit   ref_loaded, ref_err;
  int   total, passed, cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: commits are popped from the scoreboard; between commits the buses must hold.
  always @(negedge clk) begin
    cfg_t act;
    exp_t e;
    act = {bias_h, bias_x, weight_h, weight_x};
    if (done === 1'b1) begin
      chk("valid_strobes", 256'({weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid}),
          256'({4*NG{1'b1}}));
      if (sb.size() == 0) begin
        chk("unexpected_done", 256'(1), 256'(0));
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 256'(cyc), 256'(e.cyc));
        for (int k = 0; k < 4; k++) chk("commit_kind", 256'(act[2'(k)]), 256'(e.cfg[2'(k)]));
        ref_act = e.cfg;
      end
    end else if (cyc > 1) begin
      chk("strobes_idle", 256'({weight_x_valid, weight_h_valid, bias_x_valid, bias_h_valid}), 256'(0));
      for (int k = 0; k < 4; k++) chk("active_stable", 256'(act[2'(k)]), 256'(ref_act[2'(k)]));
    end
  end

  // One load attempt: last_idx<0 means cfg_last is never set; kill_at>=0 aborts or resets there.
  task automatic load(input int last_idx, input bit stall, input bit rnd, input int kill_at, input bit kill_rst);
    logic [WIDTH-1:0] d [N];
    exp_t e;
    bit lastflag;
    for (int i = 0; i < N; i++) d[i] = rnd ? WIDTH'($urandom) : WIDTH'(i + 1);
    start = 1'b1;
    step();
    start = 1'b0;
    ref_err = 1'b0;
    @(negedge clk);
    chk("busy_in_load", 256'(busy), 256'(1));
    chk("err_cleared_by_start", 256'(err), 256'(0));
    step();
    for (int i = 0; i < N; i++) begin
      if (stall) begin
        int s = int'($urandom_range(3, 0));
        for (int j = 0; j < s; j++) begin
          cfg_valid = 1'b0;
          cfg_data  = WIDTH'($urandom);
          cfg_last  = 1'($urandom_range(1, 0));
          start     = 1'($urandom_range(1, 0));
          step();
        end
        start = 1'b0;
      end
      lastflag  = (i == last_idx);
      cfg_valid = 1'b1;
      cfg_data  = d[i];
      cfg_last  = lastflag;
      if (i == kill_at) begin
        if (kill_rst) rst = 1'b1;
        else abort = 1'b1;
      end
      @(negedge clk);
      chk("cfg_ready", 256'(cfg_ready), 256'(1));
      step();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      abort     = 1'b0;
      rst       = 1'b0;
      if (i == kill_at) begin
        if (kill_rst) begin
          ref_act    = '0;
          ref_loaded = 1'b0;
          ref_err    = 1'b0;
        end
        break;
      end
      if (lastflag && i == N - 1) begin
        e.cyc = cyc;
        e.cfg = '0;
        for (int w = 0; w < N; w++) e.cfg[2'((w / 4) % 4)][4'((w / 16) * 4 + w % 4)] = d[w];
        sb.push_back(e);
        ref_loaded = 1'b1;
        break;
      end
      if (lastflag || i == N - 1) begin
        ref_err = 1'b1;
        break;
      end
    end
    repeat (3) step();
    @(negedge clk);
    chk("busy_after", 256'(busy), 256'(0));
    chk("err_after", 256'(err), 256'(ref_err));
    chk("loaded_after", 256'(loaded), 256'(ref_loaded));
    chk("commit_seen", 256'(sb.size()), 256'(0));
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    total = 0; passed = 0; cyc = 0;
    ref_act = '0; ref_loaded = 1'b0; ref_err = 1'b0;
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_cfg_ready", 256'(cfg_ready), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_loaded", 256'(loaded), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_weight_x", 256'(weight_x), 256'(0));
    step();
    rst = 1'b0; start = 1'b0;
    repeat (2) step();
    @(negedge clk);
    chk("post_rst_busy", 256'(busy), 256'(0));
    chk("post_rst_loaded", 256'(loaded), 256'(0));
    step();

    load(N - 1, 1'b0, 1'b0, -1, 1'b0);
    @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("weight_x_seq", 256'(weight_x[4'(g)]), 256'(g + 1));
      chk("weight_h_seq", 256'(weight_h[4'(g)]), 256'(g + 5));
      chk("bias_h_seq", 256'(bias_h[4'(8 + g)]), 256'(45 + g));
    end
    step();

    load(N - 1, 1'b1, 1'b1, -1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    load(10, 1'b0, 1'b1, -1, 1'b0);
    load(N - 1, 1'b1, 1'b1, -1, 1'b0);
    load(-1, 1'b0, 1'b1, -1, 1'b0);
    load(N - 1, 1'b0, 1'b1, 20, 1'b0);
    load(N - 1, 1'b1, 1'b1, 20, 1'b1);
    for (int r = 0; r < 3; r++) load(N - 1, 1'b1, 1'b1, -1, 1'b0);
    load(int'($urandom_range(N - 2, 0)), 1'b1, 1'b1, -1, 1'b0);
    repeat (4) step();
    chk("scoreboard_empty", 256'(sb.size()), 256'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
